spi_slave_rx: RTL and testbench

- SPI receiving end for the 12-bit SPI transmitter link: samples `cs`/`sclk`/`mosi` with the system clock and reassembles LSB-first words.
- Presents each received word on `dout`, with a one-cycle `valid` strobe when `cs` deasserts.
- Sits on the peripheral side of the link and feeds a local register/consumer.
- Flags frames that end early.

---
 rtl/spi_slave_rx.sv | 235 +++++++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx
//
// Receiving end of the 12-bit SPI link. The chip select, serial clock and data
// pins are asynchronous to the system clock, so each one is synchronised with
// two flops. The edges of cs and sclk are then detected against one more
// history flop. Words arrive LSB first.
//
// After cs falls, the first LEAD_EDGES falling edges of sclk are dropped.
// The next DATA_W falling edges each capture one data bit. Any further sclk
// edges are ignored until cs rises again.
//
// When cs rises after a complete word, that word is copied to dout and valid
// pulses for one clock. When cs rises before the word is complete, frame_err
// pulses for one clock instead, and dout keeps its previous value.
//
// Ports:
//   clk        system clock; all logic runs on the rising edge
//   rst_n      asynchronous active-low reset
//   cs         chip select from the master, active low, asynchronous
//   sclk       serial clock from the master, asynchronous
//   mosi       serial data; changes after sclk rises, sampled on sclk fall
//   dout       last good word; held until the next good frame completes
//   valid      one-clock pulse when dout updates
//   frame_err  one-clock pulse when a frame ends early
//   busy       high while a frame is in progress
// -----------------------------------------------------------------------------
module spi_slave_rx #(
  parameter int DATA_W     = 12,
  parameter int LEAD_EDGES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W  = $clog2(DATA_W) + 1;
  localparam int LEAD_W = $clog2(LEAD_EDGES + 1) + 1;

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [LEAD_W-1:0] LEAD_LAST =
    LEAD_W'((LEAD_EDGES > 0) ? (LEAD_EDGES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    WAIT_END
  } state_t;

  state_t state, state_next;

  // Synchroniser stages, plus the history flops used for edge detection.
  logic cs_s1, cs_s2, cs_d;
  logic sclk_s1, sclk_s2, sclk_d;
  logic mosi_s1, mosi_s2;

  logic cs_fall, cs_rise, sclk_fall;

  // Start-up qualification of cs. This stops a cs that is already low at
  // reset release from looking like a new frame.
  logic [1:0] fill;
  logic       armed;

  logic [CNT_W-1:0]  bit_cnt;
  logic [LEAD_W-1:0] lead_cnt;
  logic [DATA_W-1:0] shreg;

  // One-cycle strobes from the FSM to the datapath.
  logic clr_frame;
  logic lead_inc;
  logic shift_en;
  logic load_dout;
  logic err_set;

  // Two-flop synchronisers and one history stage.
  // The reset values match an idle bus (cs high, sclk low), so reset
  // itself does not create a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign cs_fall   =  cs_d & ~cs_s2;
  assign cs_rise   = ~cs_d &  cs_s2;
  assign sclk_fall =  sclk_d & ~sclk_s2;

  // cs_s2 only shows the real pin level once two clocks have passed after
  // reset. From then on, the receiver arms the first time it sees cs high.
  // So a master that held cs low through reset must release cs before the
  // next falling edge of cs starts a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      fill <= {fill[0], 1'b1};
      if (fill[1] && cs_s2) begin
        armed <= 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and datapath strobes.
  // A rising edge of cs is checked before a falling edge of sclk in the
  // same cycle. So a frame that ends at the same moment as its last
  // data edge is still treated as short.
  always_comb begin
    state_next = state;
    clr_frame  = 1'b0;
    lead_inc   = 1'b0;
    shift_en   = 1'b0;
    load_dout  = 1'b0;
    err_set    = 1'b0;

    case (state)
      IDLE: begin
        if (cs_fall && armed) begin
          clr_frame  = 1'b1;
          state_next = (LEAD_EDGES == 0) ? SHIFT : LEAD;
        end
      end

      LEAD: begin
        if (cs_rise) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end else if (sclk_fall) begin
          lead_inc = 1'b1;
          if (lead_cnt == LEAD_LAST) begin
            state_next = SHIFT;
          end
        end
      end

      SHIFT: begin
        if (cs_rise) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end else if (sclk_fall) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) begin
            state_next = WAIT_END;
          end
        end
      end

      WAIT_END: begin
        if (cs_rise) begin
          load_dout  = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Frame datapath: counters, shift register, output word and pulses.
  // Bits are written by index rather than shifted, so the first bit
  // received ends up in bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      lead_cnt  <= '0;
      shreg     <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= load_dout;
      frame_err <= err_set;

      if (clr_frame) begin
        bit_cnt  <= '0;
        lead_cnt <= '0;
        shreg    <= '0;
      end

      if (lead_inc) begin
        lead_cnt <= lead_cnt + LEAD_W'(1);
      end

      if (shift_en) begin
        for (int i = 0; i < DATA_W; i++) begin
          if (bit_cnt == CNT_W'(i)) begin
            shreg[i] <= mosi_s2;
          end
        end
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if (load_dout) begin
        dout <= shreg;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_slave_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_rx
//
// Self-checking testbench for spi_slave_rx.
//
// The bench drives SPI frames with the master's timing: each half period of
// sclk lasts 11 clk cycles. Before cs is raised on a good frame, the word
// the receiver should report is pushed onto a queue.
//
// A monitor pops one expected word each time valid pulses and compares it
// with dout. It also counts the valid and frame_err pulses.
//
// Each test task drives its own scenario. Using those pulse counts, it checks
// timing, busy, and which pulses occurred.
// -----------------------------------------------------------------------------
module tb_spi_slave_rx;

  localparam int DATA_W = 12;
  localparam int H      = 11;

  logic              clk;
  logic              rst_n;
  logic              cs;
  logic              sclk;
  logic              mosi;
  logic [DATA_W-1:0] dout;
  logic              valid;
  logic              frame_err;
  logic              busy;

  int checks     = 0;
  int errors     = 0;
  int valid_seen = 0;
  int ferr_seen  = 0;

  logic [DATA_W-1:0] exp_q[$];

  spi_slave_rx #(
    .DATA_W    (DATA_W),
    .LEAD_EDGES(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .sclk     (sclk),
    .mosi     (mosi),
    .dout     (dout),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: on every valid pulse it compares dout with the
  // oldest expected word. It also checks that valid and frame_err never
  // pulse in the same cycle.
  always @(negedge clk) begin
    if (valid || frame_err) begin
      checks++;
      if (valid && frame_err) begin
        errors++;
        $display("[TB] FAIL pulse_exclusive: valid=%b frame_err=%b, required not both high", valid, frame_err);
      end
    end
    if (valid) begin
      logic [DATA_W-1:0] exp_word;
      valid_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_valid: dout=%h with no word expected", dout);
      end else begin
        exp_word = exp_q.pop_front();
        if (dout !== exp_word) begin
          errors++;
          $display("[TB] FAIL scoreboard_dout: got %h expected %h", dout, exp_word);
        end
      end
    end
    if (frame_err) begin
      ferr_seen++;
    end
  end

  // Watchdog, so that a stuck run still ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One full sclk period (rising edge, then falling edge).
  // The data bit is put on mosi at the rising edge, as the master does.
  task automatic sclk_cycle(input logic b);
    sclk = 1'b1;
    mosi = b;
    repeat (H) @(negedge clk);
    sclk = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  // One lead edge, then nbits data bits LSB first, then some trailing edges.
  task automatic send_bits(input logic [DATA_W-1:0] data, input int nbits, input int trailing);
    sclk_cycle(1'b0);
    for (int i = 0; i < nbits; i++) begin
      sclk_cycle(data[i]);
    end
    for (int t = 0; t < trailing; t++) begin
      sclk_cycle(1'b0);
    end
  endtask

  task automatic start_frame();
    cs = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic end_frame();
    cs = 1'b1;
    mosi = 1'b0;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic good_frame(input logic [DATA_W-1:0] data, input int trailing);
    start_frame();
    send_bits(data, DATA_W, trailing);
    exp_q.push_back(data);
    end_frame();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cs    = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dout !== 12'h000) begin errors++; $display("[TB] FAIL reset_dout: got %h expected 000", dout); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_nominal();
    int v0, f0, lat;
    v0 = valid_seen;
    f0 = ferr_seen;
    cs = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL nominal_busy_start: got %b expected 1", busy); end
    repeat (H - 4) @(negedge clk);
    send_bits(12'hA5C, DATA_W, 1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL nominal_busy_mid: got %b expected 1", busy); end
    exp_q.push_back(12'hA5C);
    cs = 1'b1;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (valid) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 3) begin errors++; $display("[TB] FAIL nominal_latency: got %0d cycles expected 3", lat); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nominal_busy_end: got %b expected 0", busy); end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("[TB] FAIL nominal_valid_width: got %b expected 0", valid); end
    repeat (2 * H) @(negedge clk);
    checks++;
    if (valid_seen - v0 != 1) begin errors++; $display("[TB] FAIL nominal_valid_count: got %0d expected 1", valid_seen - v0); end
    checks++;
    if (ferr_seen - f0 != 0) begin errors++; $display("[TB] FAIL nominal_ferr_count: got %0d expected 0", ferr_seen - f0); end
  endtask

  task automatic test_back_to_back();
    int v0, f0;
    v0 = valid_seen;
    f0 = ferr_seen;
    good_frame(12'hFFF, 1);
    checks++;
    if (dout !== 12'hFFF) begin errors++; $display("[TB] FAIL b2b_first_dout: got %h expected FFF", dout); end
    good_frame(12'h001, 1);
    checks++;
    if (dout !== 12'h001) begin errors++; $display("[TB] FAIL b2b_second_dout: got %h expected 001", dout); end
    checks++;
    if (valid_seen - v0 != 2) begin errors++; $display("[TB] FAIL b2b_valid_count: got %0d expected 2", valid_seen - v0); end
    checks++;
    if (ferr_seen - f0 != 0) begin errors++; $display("[TB] FAIL b2b_ferr_count: got %0d expected 0", ferr_seen - f0); end
  endtask

  task automatic test_short_frame();
    int v0, f0;
    good_frame(12'h123, 1);
    v0 = valid_seen;
    f0 = ferr_seen;
    start_frame();
    send_bits(12'h3C3, 7, 0);
    end_frame();
    checks++;
    if (ferr_seen - f0 != 1) begin errors++; $display("[TB] FAIL short_ferr_count: got %0d expected 1", ferr_seen - f0); end
    checks++;
    if (valid_seen - v0 != 0) begin errors++; $display("[TB] FAIL short_valid_count: got %0d expected 0", valid_seen - v0); end
    checks++;
    if (dout !== 12'h123) begin errors++; $display("[TB] FAIL short_dout_held: got %h expected 123", dout); end
  endtask

  task automatic test_extra_edges();
    int v0, f0;
    v0 = valid_seen;
    f0 = ferr_seen;
    good_frame(12'h800, 3);
    checks++;
    if (dout !== 12'h800) begin errors++; $display("[TB] FAIL extra_dout: got %h expected 800", dout); end
    checks++;
    if (valid_seen - v0 != 1) begin errors++; $display("[TB] FAIL extra_valid_count: got %0d expected 1", valid_seen - v0); end
    checks++;
    if (ferr_seen - f0 != 0) begin errors++; $display("[TB] FAIL extra_ferr_count: got %0d expected 0", ferr_seen - f0); end
  endtask

  task automatic test_reset_mid_frame();
    int v0, f0;
    v0 = valid_seen;
    f0 = ferr_seen;
    start_frame();
    send_bits(12'h7E7, 5, 0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 12'h000) begin errors++; $display("[TB] FAIL midrst_dout: got %h expected 000", dout); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++;
    if (valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_pulses: valid=%b frame_err=%b expected 0/0", valid, frame_err);
    end
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    end_frame();
    checks++;
    if (valid_seen - v0 != 0) begin errors++; $display("[TB] FAIL midrst_valid_count: got %0d expected 0", valid_seen - v0); end
    checks++;
    if (ferr_seen - f0 != 0) begin errors++; $display("[TB] FAIL midrst_ferr_count: got %0d expected 0", ferr_seen - f0); end
    good_frame(12'h5A5, 1);
    checks++;
    if (dout !== 12'h5A5) begin errors++; $display("[TB] FAIL midrst_next_dout: got %h expected 5A5", dout); end
  endtask

  task automatic test_cs_low_at_reset();
    int v0, f0;
    rst_n = 1'b0;
    cs    = 1'b0;
    sclk  = 1'b0;
    mosi  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    v0 = valid_seen;
    f0 = ferr_seen;
    repeat (H) @(negedge clk);
    send_bits(12'hABC, DATA_W, 1);
    end_frame();
    checks++;
    if (valid_seen - v0 != 0) begin errors++; $display("[TB] FAIL cslow_valid_count: got %0d expected 0", valid_seen - v0); end
    checks++;
    if (ferr_seen - f0 != 0) begin errors++; $display("[TB] FAIL cslow_ferr_count: got %0d expected 0", ferr_seen - f0); end
    checks++;
    if (dout !== 12'h000) begin errors++; $display("[TB] FAIL cslow_dout: got %h expected 000", dout); end
    v0 = valid_seen;
    good_frame(12'h0F0, 1);
    checks++;
    if (valid_seen - v0 != 1) begin errors++; $display("[TB] FAIL cslow_next_valid_count: got %0d expected 1", valid_seen - v0); end
    checks++;
    if (dout !== 12'h0F0) begin errors++; $display("[TB] FAIL cslow_next_dout: got %h expected 0F0", dout); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_short_frame();
    test_extra_edges();
    test_reset_mid_frame();
    test_cs_low_at_reset();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d words still expected, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
